interpretador_andar_n: RTL and testbench
========================================

INTERPRETADOR_ANDAR_N -- requirements
Module: interpretador_andar_n

Interface
REQ-001 Parameter N_ANDARES, default 4: number of floors and floor sensors; legal range 2..16.
REQ-002 Parameter W_ANDAR, default 2: floor index width; SHALL equal ceil(log2(N_ANDARES)).
REQ-003 Parameter DEBOUNCE_CICLOS, default 4: consecutive identical samples required before a sensor vector is accepted; legal range 1..255.
REQ-004 Parameter TIMEOUT_CICLOS, default 50000000: maximum wait for the ultrasonic answer, in clock cycles.
REQ-005 clock  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 medir  in  1  measurement request, sampled high on one rising edge.
REQ-008 sensores  in  N_ANDARES  floor sensors; bit i set means the cabin is at floor i.
REQ-009 andar_us  in  W_ANDAR  floor index reported by the ultrasonic subsystem.
REQ-010 andar_us_valido  in  1  one-cycle strobe; andar_us is valid while high.
REQ-011 medir_us  out  1  one-cycle request to the ultrasonic subsystem.
REQ-012 saida_andar  out  W_ANDAR  last accepted floor index.
REQ-013 fonte  out  1  source of saida_andar: 1 = floor sensor, 0 = ultrasonic.
REQ-014 valido  out  1  saida_andar holds a floor accepted by the last completed request.
REQ-015 erro  out  1  last completed request failed.
REQ-016 ocupado  out  1  a request is in progress.
REQ-017 pronto  out  1  one-cycle strobe at request completion.

Function
REQ-018 Filter SHALL compare sensores to the previous sample every cycle: equal -> increment stability counter, saturating; different -> clear the counter.
REQ-019 Filter SHALL load the current sample into the filtered vector when the counter reaches DEBOUNCE_CICLOS-1.
REQ-020 Filter SHALL run in every FSM state, independent of medir.
REQ-021 Filtered-vector classes: all zero = NENHUM; exactly one bit set = ONE-HOT, carrying that bit's index; two or more bits set = CONFLITO.
REQ-022 FSM states: ESPERA, PEDE_US, AGUARDA_US, CONCLUI. ocupado SHALL be 1 in every state except ESPERA.
REQ-023 ESPERA + medir at edge k, class ONE-HOT: at edge k+1, saida_andar=index, fonte=1, valido=1, erro=0, pronto=1.
REQ-024 ESPERA + medir at edge k, class CONFLITO: at edge k+1, erro=1, valido=0, pronto=1; saida_andar and fonte unchanged.
REQ-025 ESPERA + medir at edge k, class NENHUM: medir_us=1 for exactly the cycle following edge k; FSM enters AGUARDA_US and clears the timeout counter.
REQ-026 AGUARDA_US, andar_us_valido sampled at edge j with andar_us < N_ANDARES: at edge j+1, saida_andar=andar_us, fonte=0, valido=1, erro=0, pronto=1.
REQ-027 AGUARDA_US, andar_us_valido with andar_us >= N_ANDARES: at edge j+1, erro=1, valido=0, pronto=1; saida_andar unchanged.
REQ-028 AGUARDA_US with the filtered class becoming ONE-HOT: the wait SHALL be aborted and the sensor result committed as in REQ-023; a later andar_us_valido SHALL be ignored.
REQ-029 Timeout: TIMEOUT_CICLOS cycles after medir_us was asserted with no strobe -> erro=1, valido=0, pronto=1; return to ESPERA.
REQ-030 If andar_us_valido and timeout expiry fall on the same edge, the strobe SHALL win.
REQ-031 medir asserted while ocupado=1 SHALL be ignored and not queued.
REQ-032 andar_us_valido while in ESPERA SHALL be ignored.
REQ-033 After pronto the FSM SHALL return to ESPERA; a new medir is accepted on the edge immediately after pronto.
REQ-034 pronto and medir_us SHALL never be high for more than one consecutive cycle.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 On reset: saida_andar=0, fonte=0, valido=0, erro=0, pronto=0, medir_us=0, ocupado=0; FSM in ESPERA; filtered vector, previous sample and all counters cleared.
REQ-037 Reset asserted mid-request SHALL abort the request with no pronto; a strobe arriving after reset release SHALL be ignored.

Verification (N_ANDARES=4, DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=16)
REQ-038 sensores=0100 held 6 cycles, then medir pulse -> one cycle later pronto=1, saida_andar=2, fonte=1, valido=1, erro=0.
REQ-039 sensores=0000, medir -> medir_us pulse of 1 cycle; andar_us=3 with strobe 5 cycles later -> pronto, saida_andar=3, fonte=0, valido=1.
REQ-040 sensores glitch 0000->1000 for 2 cycles only, then medir -> ultrasonic path taken (medir_us=1), not sensor path.
REQ-041 sensores=0110 stable, medir -> pronto, erro=1, valido=0, saida_andar unchanged; separately, ultrasonic path with no strobe -> pronto and erro=1 exactly 16 cycles after medir_us.
REQ-042 During AGUARDA_US: second medir ignored; sensores=0001 stabilises -> pronto, saida_andar=0, fonte=1; later strobe produces no pronto.
REQ-043 Reset pulse while in AGUARDA_US -> all outputs at reset values, no pronto, ocupado=0.

Source files
------------

// File: rtl/interpretador_andar_n.sv
// Floor interpreter: debounces one-hot floor sensors and falls back to an
// ultrasonic measurement when no sensor is active, with timeout handling.
module interpretador_andar_n #(
    parameter int N_ANDARES       = 4,
    parameter int W_ANDAR         = 2,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 50000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               medir,
    input  logic [N_ANDARES-1:0] sensores,
    input  logic [W_ANDAR-1:0] andar_us,
    input  logic               andar_us_valido,
    output logic               medir_us,
    output logic [W_ANDAR-1:0] saida_andar,
    output logic               fonte,
    output logic               valido,
    output logic               erro,
    output logic               ocupado,
    output logic               pronto
);

    typedef enum logic [1:0] {ESPERA, PEDE_US, AGUARDA_US, CONCLUI} estado_t;

    localparam logic [7:0]  LIMIAR  = 8'(DEBOUNCE_CICLOS - 1);
    // The PEDE_US cycle and the expiry edge itself account for two of the cycles.
    localparam logic [31:0] TMR_LIM = (TIMEOUT_CICLOS > 2) ? 32'(TIMEOUT_CICLOS - 2) : 32'd0;

    estado_t              estado_q, estado_d;
    logic [N_ANDARES-1:0] amostra_q, amostra_d;
    logic [N_ANDARES-1:0] filt_q, filt_d;
    logic [7:0]           estavel_q, estavel_d;
    logic [31:0]          tmr_q, tmr_d;
    logic [W_ANDAR-1:0]   saida_q, saida_d;
    logic                 fonte_q, fonte_d;
    logic                 valido_q, valido_d;
    logic                 erro_q, erro_d;
    logic                 pronto_q, pronto_d;
    logic                 medir_us_q, medir_us_d;
    logic                 ocupado_q, ocupado_d;

    logic [4:0]           n_set;
    logic [W_ANDAR-1:0]   idx;
    logic                 one_hot;
    logic                 conflito;
    logic                 us_em_faixa;

    always_comb begin
        amostra_d = sensores;
        estavel_d = estavel_q;
        filt_d    = filt_q;
        if (sensores == amostra_q) begin
            if (estavel_q != 8'hFF) begin
                estavel_d = estavel_q + 8'd1;
            end
        end else begin
            estavel_d = 8'd0;
        end
        if (estavel_d >= LIMIAR) begin
            filt_d = sensores;
        end
    end

    always_comb begin
        n_set = 5'd0;
        idx   = '0;
        for (int i = 0; i < N_ANDARES; i++) begin
            if (filt_q[i]) begin
                n_set = n_set + 5'd1;
                idx   = W_ANDAR'(i);
            end
        end
        one_hot     = (n_set == 5'd1);
        conflito    = (n_set > 5'd1);
        us_em_faixa = (32'(andar_us) < N_ANDARES);
    end

    always_comb begin
        estado_d = estado_q;
        tmr_d    = tmr_q;
        saida_d  = saida_q;
        fonte_d  = fonte_q;
        valido_d = valido_q;
        erro_d   = erro_q;
        case (estado_q)
            ESPERA: begin
                if (medir) begin
                    if (one_hot) begin
                        saida_d  = idx;
                        fonte_d  = 1'b1;
                        valido_d = 1'b1;
                        erro_d   = 1'b0;
                        estado_d = CONCLUI;
                    end else if (conflito) begin
                        valido_d = 1'b0;
                        erro_d   = 1'b1;
                        estado_d = CONCLUI;
                    end else begin
                        estado_d = PEDE_US;
                    end
                end
            end
            PEDE_US: begin
                tmr_d    = 32'd0;
                estado_d = AGUARDA_US;
            end
            AGUARDA_US: begin
                // Strobe beats both a sensor abort and timeout expiry on the same edge.
                if (andar_us_valido) begin
                    if (us_em_faixa) begin
                        saida_d  = andar_us;
                        fonte_d  = 1'b0;
                        valido_d = 1'b1;
                        erro_d   = 1'b0;
                    end else begin
                        valido_d = 1'b0;
                        erro_d   = 1'b1;
                    end
                    estado_d = CONCLUI;
                end else if (one_hot) begin
                    saida_d  = idx;
                    fonte_d  = 1'b1;
                    valido_d = 1'b1;
                    erro_d   = 1'b0;
                    estado_d = CONCLUI;
                end else if (tmr_q >= TMR_LIM) begin
                    valido_d = 1'b0;
                    erro_d   = 1'b1;
                    estado_d = CONCLUI;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
        medir_us_d = (estado_d == PEDE_US);
        pronto_d   = (estado_d == CONCLUI);
        ocupado_d  = (estado_d != ESPERA);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= ESPERA;
            amostra_q  <= '0;
            filt_q     <= '0;
            estavel_q  <= 8'd0;
            tmr_q      <= 32'd0;
            saida_q    <= '0;
            fonte_q    <= 1'b0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
            pronto_q   <= 1'b0;
            medir_us_q <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            amostra_q  <= amostra_d;
            filt_q     <= filt_d;
            estavel_q  <= estavel_d;
            tmr_q      <= tmr_d;
            saida_q    <= saida_d;
            fonte_q    <= fonte_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
            pronto_q   <= pronto_d;
            medir_us_q <= medir_us_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign medir_us    = medir_us_q;
    assign saida_andar = saida_q;
    assign fonte       = fonte_q;
    assign valido      = valido_q;
    assign erro        = erro_q;
    assign ocupado     = ocupado_q;
    assign pronto      = pronto_q;

endmodule

// File: tb/tb_interpretador_andar_n.sv
// Directed bench for interpretador_andar_n: vector table plus hand-written
// sequences for timeout, glitch rejection, abort, reset and out-of-range floors.
module tb_interpretador_andar_n;

    logic       clock = 1'b0;
    logic       reset;
    logic       medir;
    logic [3:0] sensores;
    logic [1:0] andar_us;
    logic       andar_us_valido;
    logic       medir_us, fonte, valido, erro, ocupado, pronto;
    logic [1:0] saida_andar;

    logic       medir3;
    logic [2:0] sensores3;
    logic [1:0] andar_us3;
    logic       andar_us_valido3;
    logic       medir_us3, fonte3, valido3, erro3, ocupado3, pronto3;
    logic [1:0] saida_andar3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    interpretador_andar_n #(.N_ANDARES(4), .W_ANDAR(2), .DEBOUNCE_CICLOS(4), .TIMEOUT_CICLOS(16)) dut (
        .clock(clock), .reset(reset), .medir(medir), .sensores(sensores),
        .andar_us(andar_us), .andar_us_valido(andar_us_valido), .medir_us(medir_us),
        .saida_andar(saida_andar), .fonte(fonte), .valido(valido), .erro(erro),
        .ocupado(ocupado), .pronto(pronto));

    interpretador_andar_n #(.N_ANDARES(3), .W_ANDAR(2), .DEBOUNCE_CICLOS(4), .TIMEOUT_CICLOS(16)) dut3 (
        .clock(clock), .reset(reset), .medir(medir3), .sensores(sensores3),
        .andar_us(andar_us3), .andar_us_valido(andar_us_valido3), .medir_us(medir_us3),
        .saida_andar(saida_andar3), .fonte(fonte3), .valido(valido3), .erro(erro3),
        .ocupado(ocupado3), .pronto(pronto3));

    typedef struct {
        logic [3:0] sens;
        bit         us;
        int         dly;
        logic [1:0] aus;
        logic [1:0] e_saida;
        bit         e_fonte;
        bit         e_valido;
        bit         e_erro;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        sensores = v.sens;
        repeat (6) tick();
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk($sformatf("v%0d_medir_us", n), int'(medir_us), int'(v.us));
        if (v.us) begin
            chk($sformatf("v%0d_no_early_pronto", n), int'(pronto), 0);
            for (int i = 0; i < v.dly; i++) begin
                tick();
                if (i == 0) chk($sformatf("v%0d_medir_us_one_cycle", n), int'(medir_us), 0);
            end
            andar_us = v.aus;
            andar_us_valido = 1'b1;
            tick();
            andar_us_valido = 1'b0;
        end
        chk($sformatf("v%0d_pronto", n), int'(pronto), 1);
        chk($sformatf("v%0d_saida", n), int'(saida_andar), int'(v.e_saida));
        chk($sformatf("v%0d_fonte", n), int'(fonte), int'(v.e_fonte));
        chk($sformatf("v%0d_valido", n), int'(valido), int'(v.e_valido));
        chk($sformatf("v%0d_erro", n), int'(erro), int'(v.e_erro));
        chk($sformatf("v%0d_ocupado_busy", n), int'(ocupado), 1);
        tick();
        chk($sformatf("v%0d_pronto_one_cycle", n), int'(pronto), 0);
        chk($sformatf("v%0d_ocupado_idle", n), int'(ocupado), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit late;
        bit early;

        tbl[0] = '{4'b0100, 1'b0, 0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{4'b0000, 1'b1, 5, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{4'b0001, 1'b0, 0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{4'b0110, 1'b0, 0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4'b1000, 1'b0, 0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{4'b0000, 1'b1, 2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'b1111, 1'b0, 0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        medir = 1'b0;
        sensores = 4'b0000;
        andar_us = 2'd0;
        andar_us_valido = 1'b0;
        medir3 = 1'b0;
        sensores3 = 3'b000;
        andar_us3 = 2'd0;
        andar_us_valido3 = 1'b0;
        tick();
        tick();
        chk("rst_saida", int'(saida_andar), 0);
        chk("rst_flags", int'({fonte, valido, erro, pronto, medir_us, ocupado}), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // Timeout with no strobe: pronto exactly 16 cycles after medir_us.
        sensores = 4'b0000;
        repeat (6) tick();
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("tmo_medir_us", int'(medir_us), 1);
        early = 1'b0;
        repeat (15) begin
            tick();
            if (pronto) early = 1'b1;
        end
        chk("tmo_no_early_pronto", int'(early), 0);
        tick();
        chk("tmo_pronto", int'(pronto), 1);
        chk("tmo_erro", int'(erro), 1);
        chk("tmo_valido", int'(valido), 0);
        chk("tmo_saida_kept", int'(saida_andar), 1);
        tick();

        // Strobe on the same edge as timeout expiry wins.
        medir = 1'b1;
        tick();
        medir = 1'b0;
        repeat (15) tick();
        andar_us = 2'd2;
        andar_us_valido = 1'b1;
        tick();
        andar_us_valido = 1'b0;
        chk("tie_pronto", int'(pronto), 1);
        chk("tie_valido", int'(valido), 1);
        chk("tie_erro", int'(erro), 0);
        chk("tie_saida", int'(saida_andar), 2);
        tick();

        // Two-cycle glitch must not reach the filtered vector.
        sensores = 4'b1000;
        tick();
        tick();
        sensores = 4'b0000;
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("glitch_medir_us", int'(medir_us), 1);
        chk("glitch_no_pronto", int'(pronto), 0);
        tick();
        andar_us = 2'd1;
        andar_us_valido = 1'b1;
        tick();
        andar_us_valido = 1'b0;
        chk("glitch_saida", int'(saida_andar), 1);
        chk("glitch_fonte", int'(fonte), 0);
        tick();

        // Sensor stabilising during the wait aborts it; later strobe ignored.
        medir = 1'b1;
        tick();
        medir = 1'b0;
        tick();
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("abort_second_medir_ignored", int'(medir_us), 0);
        sensores = 4'b0001;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pronto) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_pronto_seen", int'(got), 1);
        chk("abort_saida", int'(saida_andar), 0);
        chk("abort_fonte", int'(fonte), 1);
        chk("abort_valido", int'(valido), 1);
        tick();
        andar_us = 2'd3;
        andar_us_valido = 1'b1;
        tick();
        andar_us_valido = 1'b0;
        late = 1'b0;
        repeat (3) begin
            tick();
            if (pronto || medir_us || ocupado) late = 1'b1;
        end
        chk("abort_late_strobe_ignored", int'(late), 0);
        chk("abort_saida_kept", int'(saida_andar), 0);

        // medir held across the pronto cycle: ignored once, accepted on the next edge.
        sensores = 4'b0100;
        repeat (6) tick();
        medir = 1'b1;
        tick();
        chk("b2b_pronto1", int'(pronto), 1);
        chk("b2b_saida", int'(saida_andar), 2);
        tick();
        chk("b2b_pronto_gap", int'(pronto), 0);
        chk("b2b_ocupado_gap", int'(ocupado), 0);
        tick();
        medir = 1'b0;
        chk("b2b_pronto2", int'(pronto), 1);
        tick();

        // Reset in the middle of an ultrasonic wait.
        sensores = 4'b0000;
        repeat (6) tick();
        medir = 1'b1;
        tick();
        medir = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy", int'(ocupado), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_saida", int'(saida_andar), 0);
        chk("rst_mid_flags", int'({fonte, valido, erro, pronto, medir_us, ocupado}), 0);
        tick();
        reset = 1'b0;
        andar_us = 2'd3;
        andar_us_valido = 1'b1;
        tick();
        andar_us_valido = 1'b0;
        late = 1'b0;
        repeat (2) begin
            tick();
            if (pronto || ocupado || valido) late = 1'b1;
        end
        chk("rst_mid_strobe_ignored", int'(late), 0);
        chk("rst_mid_saida_after", int'(saida_andar), 0);

        // Out-of-range ultrasonic floor on a 3-floor instance.
        medir3 = 1'b1;
        tick();
        medir3 = 1'b0;
        chk("n3_medir_us", int'(medir_us3), 1);
        tick();
        andar_us3 = 2'd3;
        andar_us_valido3 = 1'b1;
        tick();
        andar_us_valido3 = 1'b0;
        chk("n3_oor_pronto", int'(pronto3), 1);
        chk("n3_oor_erro", int'(erro3), 1);
        chk("n3_oor_valido", int'(valido3), 0);
        chk("n3_oor_saida", int'(saida_andar3), 0);
        tick();
        medir3 = 1'b1;
        tick();
        medir3 = 1'b0;
        tick();
        andar_us3 = 2'd2;
        andar_us_valido3 = 1'b1;
        tick();
        andar_us_valido3 = 1'b0;
        chk("n3_ok_pronto", int'(pronto3), 1);
        chk("n3_ok_erro", int'(erro3), 0);
        chk("n3_ok_valido", int'(valido3), 1);
        chk("n3_ok_saida", int'(saida_andar3), 2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
